// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and FSM state type for the 7-segment scan path.
//   N_DIGITS    number of display digits
//   DIGIT_W     width of the digit select
//   ANODES_OFF  active-low anode vector with every digit dark
//   state_t     scan FSM states (IDLE, BLANK, ON)
package seg_pkg;

    localparam int N_DIGITS = 4;
    localparam int DIGIT_W  = 2;
    localparam logic [N_DIGITS-1:0] ANODES_OFF = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        ON
    } state_t;

endpackage

// File: rtl/slot_timer.sv
// slot_timer: free-running slot counter, 0..CLK_DIV-1, wrapping.
//   i_clk   system clock
//   i_rst   synchronous reset, active-high
//   i_clr   synchronous clear (count returns to 0 on the next edge)
//   o_cnt   current count
//   o_last  high while o_cnt == CLK_DIV-1
module slot_timer #(
    parameter int unsigned CLK_DIV = 50000
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_clr,
    output logic [$clog2(CLK_DIV)-1:0] o_cnt,
    output logic                       o_last
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = w_last;

endmodule

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: time-multiplexed scan controller for a 4-digit 7-segment
// display, with a blanking gap at each digit change, 16-level PWM brightness
// and per-digit masking.
//   i_clk         system clock
//   i_rst         synchronous reset, active-high (priority over i_en)
//   i_en          scan enable; 0 = display dark, scan parked at digit 0
//   i_bright      brightness, sampled while slot count is 0
//   i_digit_mask  bit d = 1: digit d may light
//   o_ctrl        digit select to the digit MUX
//   o_anode_n     active-low anodes, at most one bit low
//   o_blank       high in IDLE or BLANK
//   o_frame_tick  1-cycle pulse on the last cycle of slot 3
module digit_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic [3:0]          i_bright,
    input  logic [N_DIGITS-1:0] i_digit_mask,
    output logic [DIGIT_W-1:0]  o_ctrl,
    output logic [N_DIGITS-1:0] o_anode_n,
    output logic                o_blank,
    output logic                o_frame_tick
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);

    generate
        if (BLANK_CYCLES < 2 || CLK_DIV <= BLANK_CYCLES + 1) begin : g_param_check
            $error("digit_scan_ctrl: need BLANK_CYCLES >= 2 and CLK_DIV > BLANK_CYCLES+1");
        end
    endgenerate

    state_t              r_state, w_state_next;
    logic [DIGIT_W-1:0]  r_digit, w_digit_next;
    logic [3:0]          r_pwm, w_pwm_next;
    logic [3:0]          r_bright_q;
    logic [N_DIGITS-1:0] r_anode_n, w_anode_next;
    logic                r_blank, r_tick, w_tick_next;
    logic [CNT_W-1:0]    w_cnt;
    logic                w_last;
    logic                w_clr;

    // Counter is held at 0 while parked so the first BLANK cycle sees slot 0.
    assign w_clr = !i_en || (r_state == IDLE);

    slot_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_slot_timer (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_clr),
        .o_cnt  (w_cnt),
        .o_last (w_last)
    );

    // Outputs are registered from next-state values, so each output reflects
    // the state the FSM occupies during the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_digit_next = r_digit;
        w_pwm_next   = '0;
        w_tick_next  = 1'b0;
        w_anode_next = ANODES_OFF;

        if (!i_en) begin
            w_state_next = IDLE;
            w_digit_next = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_next = BLANK;
                    w_digit_next = '0;
                end
                BLANK: begin
                    if (w_cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                        w_state_next = ON;
                    end
                end
                ON: begin
                    if (w_last) begin
                        w_state_next = BLANK;
                        w_digit_next = r_digit + 1'b1;
                    end else begin
                        w_pwm_next = r_pwm + 4'd1;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_digit_next = '0;
                end
            endcase
        end

        // The tick cycle is the one after slot 3 reaches CLK_DIV-2.
        w_tick_next = i_en && (r_state != IDLE)
                      && (r_digit == DIGIT_W'(N_DIGITS - 1))
                      && (w_cnt == CNT_W'(CLK_DIV - 2));

        if (w_state_next == ON && i_digit_mask[w_digit_next]
            && w_pwm_next <= r_bright_q) begin
            w_anode_next[w_digit_next] = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_digit    <= '0;
            r_pwm      <= '0;
            r_bright_q <= '0;
            r_anode_n  <= ANODES_OFF;
            r_blank    <= 1'b1;
            r_tick     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_digit   <= w_digit_next;
            r_pwm     <= w_pwm_next;
            r_anode_n <= w_anode_next;
            r_blank   <= (w_state_next != ON);
            r_tick    <= w_tick_next;
            if (w_cnt == '0) begin
                r_bright_q <= i_bright;
            end
        end
    end

    assign o_ctrl       = r_digit;
    assign o_anode_n    = r_anode_n;
    assign o_blank      = r_blank;
    assign o_frame_tick = r_tick;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl: scoreboard bench for digit_scan_ctrl. Two instances
// (CLK_DIV=8 and CLK_DIV=20, both BLANK_CYCLES=2) share the stimulus; a
// per-instance cycle model produces expected outputs for every cycle.
module tb_digit_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [3:0] bright = 4'd15;
    logic [3:0] mask = 4'hF;

    logic [1:0] a_ctrl, b_ctrl;
    logic [3:0] a_an, b_an;
    logic       a_blank, b_blank, a_tick, b_tick;

    digit_scan_ctrl #(.CLK_DIV(8), .BLANK_CYCLES(2)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_bright(bright),
        .i_digit_mask(mask), .o_ctrl(a_ctrl), .o_anode_n(a_an),
        .o_blank(a_blank), .o_frame_tick(a_tick)
    );

    digit_scan_ctrl #(.CLK_DIV(20), .BLANK_CYCLES(2)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_bright(bright),
        .i_digit_mask(mask), .o_ctrl(b_ctrl), .o_anode_n(b_an),
        .o_blank(b_blank), .o_frame_tick(b_tick)
    );

    always #5 clk = ~clk;

    // Model state: st 0=IDLE 1=BLANK 2=ON
    typedef struct {
        int         st;
        int         dg;
        int         cnt;
        int         pwm;
        logic [3:0] bq;
        logic [3:0] mk;
    } ms_t;

    typedef struct {
        logic [1:0] ctrl;
        logic [3:0] an;
        logic       blank;
        logic       tick;
    } out_t;

    typedef struct {
        out_t a;
        out_t b;
    } exp_t;

    ms_t  ma, mb;
    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;
    int cycle_no = 0;
    int last_tick = -1;
    int gcnt = 0;
    int lit_b = 0;
    logic [1:0] prev_ctrl = 2'd0;

    function automatic ms_t mstep(ms_t m, int div, int blk, logic r, logic e,
                                  logic [3:0] br, logic [3:0] mk);
        ms_t n = m;
        n.mk = mk;
        if (m.cnt == 0) n.bq = br;
        if (r) begin
            n.st = 0; n.dg = 0; n.cnt = 0; n.pwm = 0; n.bq = 4'd0;
        end else if (!e) begin
            n.st = 0; n.dg = 0; n.cnt = 0; n.pwm = 0;
        end else if (m.st == 0) begin
            n.st = 1; n.dg = 0; n.cnt = 0; n.pwm = 0;
        end else if (m.cnt == div - 1) begin
            n.st = 1; n.dg = (m.dg + 1) % 4; n.cnt = 0; n.pwm = 0;
        end else begin
            n.cnt = m.cnt + 1;
            if (n.cnt == blk) begin
                n.st = 2; n.pwm = 0;
            end else if (m.st == 2) begin
                n.pwm = (m.pwm + 1) % 16;
            end
        end
        return n;
    endfunction

    function automatic out_t mout(ms_t m, int div);
        out_t o;
        o.an = 4'hF;
        if (m.st == 2 && m.mk[m.dg] && m.pwm <= int'(m.bq)) o.an[m.dg] = 1'b0;
        o.ctrl  = m.dg[1:0];
        o.blank = (m.st != 2);
        o.tick  = (m.st != 0 && m.dg == 3 && m.cnt == div - 1);
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cycle_no, obs, exp);
        end
    endtask

    task automatic cyc();
        exp_t e, g;
        if (rst || !en) last_tick = -1;
        ma = mstep(ma, 8, 2, rst, en, bright, mask);
        mb = mstep(mb, 20, 2, rst, en, bright, mask);
        e.a = mout(ma, 8);
        e.b = mout(mb, 20);
        sb.push_back(e);
        @(posedge clk);
        #1;
        cycle_no++;
        g = sb.pop_front();
        chk("a_ctrl",  32'(a_ctrl),  32'(g.a.ctrl));
        chk("a_anode", 32'(a_an),    32'(g.a.an));
        chk("a_blank", 32'(a_blank), 32'(g.a.blank));
        chk("a_tick",  32'(a_tick),  32'(g.a.tick));
        chk("b_ctrl",  32'(b_ctrl),  32'(g.b.ctrl));
        chk("b_anode", 32'(b_an),    32'(g.b.an));
        chk("b_blank", 32'(b_blank), 32'(g.b.blank));
        chk("b_tick",  32'(b_tick),  32'(g.b.tick));
        // anodes stay dark for BLANK_CYCLES cycles after each select change
        if (a_ctrl !== prev_ctrl) gcnt = 2;
        prev_ctrl = a_ctrl;
        if (gcnt > 0) begin
            chk("ghost", 32'(a_an), 32'hF);
            gcnt--;
        end
        chk("a_onehot", 32'($countones(~a_an) <= 1), 32'd1);
        chk("b_onehot", 32'($countones(~b_an) <= 1), 32'd1);
        if (a_tick === 1'b1) begin
            if (last_tick >= 0) chk("tick_period", 32'(cycle_no - last_tick), 32'd32);
            last_tick = cycle_no;
        end
        if (b_an !== 4'hF) lit_b++;
    endtask

    initial begin : stim
        bit found;

        // Reset held 3 cycles with enable high
        rst = 1'b1; en = 1'b1; bright = 4'd15; mask = 4'hF;
        repeat (3) cyc();
        chk("rst_anode", 32'(a_an), 32'hF);
        chk("rst_ctrl", 32'(a_ctrl), 32'd0);
        chk("rst_blank", 32'(a_blank), 32'd1);
        chk("rst_tick", 32'(a_tick), 32'd0);

        // Full-brightness scan over four frames
        rst = 1'b0;
        repeat (132) cyc();

        // Digits 1 and 3 masked
        mask = 4'b0101;
        repeat (70) cyc();
        mask = 4'hF;

        // Mid-slot stop at slot 2, cycle 4, then resume from digit 0
        en = 1'b0; cyc();
        en = 1'b1;
        repeat (21) cyc();
        chk("pre_stop_ctrl", 32'(a_ctrl), 32'd2);
        en = 1'b0; cyc();
        chk("stop_anode", 32'(a_an), 32'hF);
        chk("stop_ctrl", 32'(a_ctrl), 32'd0);
        en = 1'b1; cyc();
        chk("resume_ctrl", 32'(a_ctrl), 32'd0);
        chk("resume_blank", 32'(a_blank), 32'd1);
        cyc(); cyc();
        chk("resume_lit", 32'(a_an), 32'b1110);
        repeat (10) cyc();

        // PWM at brightness 1 on the CLK_DIV=20 instance: 4 lit cycles per slot
        en = 1'b0; bright = 4'd1; cyc();
        en = 1'b1;
        lit_b = 0;
        repeat (160) cyc();
        chk("pwm_lit_2frames", 32'(lit_b), 32'd32);

        // Mid-operation reset
        bright = 4'd15;
        repeat (13) cyc();
        rst = 1'b1; cyc();
        chk("midrst_anode", 32'(a_an), 32'hF);
        chk("midrst_ctrl", 32'(a_ctrl), 32'd0);
        rst = 1'b0;
        repeat (5) cyc();

        // Enable falls on the frame-tick cycle
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc();
            if (a_tick === 1'b1) found = 1'b1;
        end
        chk("tie_tick_seen", 32'(found), 32'd1);
        en = 1'b0; cyc();
        chk("tie_idle_blank", 32'(a_blank), 32'd1);
        chk("tie_idle_ctrl", 32'(a_ctrl), 32'd0);
        chk("tie_no_tick", 32'(a_tick), 32'd0);
        en = 1'b1;
        repeat (10) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
